uriscv_muldiv_arb: RTL
======================

# uriscv_muldiv_arb

Two-port arbiter and sequencer that shares one `uriscv_muldiv` unit between two requesters (e.g. the core execute stage and a debug/coprocessor port). It grants requests round-robin and encodes each op onto the unit's one-hot `inst_*` inputs. It models the unit's occupancy so it never presents `valid_i` into a stall. It also steers each in-order result back to the requester that issued it, with that requester's tag.

## Interface
Parameters:
- `TAG_W`, 5: width of the requester-supplied tag returned with each response.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  2  per-requester request valid; bit n belongs to requester n.
- `req_ready_o`  out  2  per-requester accept; a transfer occurs when valid & ready.
- `req_op_i`  in  2x3  per-requester op, funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `req_a_i`, `req_b_i`  in  2x32  per-requester operands.
- `req_tag_i`  in  2xTAG_W  per-requester tag.
- `rsp_valid_o`  out  2  one-cycle response pulse to requester n. Responses are non-blocking; the requester must take the pulse.
- `rsp_data_o`  out  32  result, shared by both requesters and valid only with `rsp_valid_o`.
- `rsp_tag_o`  out  TAG_W  tag of the responding op.
- `md_valid_o`, `md_inst_o[7:0]`, `md_ra_o`, `md_rb_o`  out  1/8/32/32  drive the unit's `valid_i`, `inst_*_i` (bit k = funct3 k), `operand_ra_i` and `operand_rb_i`.
- `md_stall_i`, `md_ready_i`, `md_result_i`  in  1/1/32  the unit's `stall_o`, `ready_o` and `result_o`.
- `busy_o`  out  1  high when any op is in flight.
- `err_o`  out  1  sticky protocol error flag.

## Operation
- **Op class.** funct3[2]=0 is MUL-class; funct3[2]=1 is DIV-class.
- **Eligibility.** A MUL is eligible when `div_inflight`=0. A DIV is eligible when `div_inflight`=0 and the order FIFO is empty.
  - This mirrors the unit's stall rules: a DIV stalls behind a MUL from the previous cycle, and any op stalls behind a DIV.
  - The unit captures MUL operands even while stalled, so issuing into a stall must never happen.
- **Grant.** At most one grant per cycle, only to an eligible, valid requester.
  - If both are eligible, the round-robin pointer picks the winner. After any grant, the pointer moves to the other requester.
  - The pointer resets to requester 0.
- **Issue.** Combinational in the grant cycle.
  - `md_valid_o`=1, `md_inst_o` = one-hot of the op, operands muxed from the winner.
  - When there is no grant, `md_valid_o`=0 and `md_inst_o`=0.
- **Order FIFO.** Depth 2, entries {requester id, tag}. It is pushed on every grant and popped on every `md_ready_i`.
  - Results return strictly in issue order.
  - At most 2 MULs are ever outstanding (issue N and N+1 return at N+2 and N+3).
  - Push and pop in the same cycle are legal when the FIFO is full.
- **div_inflight.** Set on a DIV grant; cleared on the `md_ready_i` that pops the DIV entry.
- **Response.** `rsp_valid_o[head.id]` = `md_ready_i`.
  - `rsp_data_o` = `md_result_i`; `rsp_tag_o` = `head.tag`.
  - Combinational from the unit's registered outputs.
- **Errors.** `err_o` sets on either of:
  - `md_ready_i` with the FIFO empty (the response is dropped; no `rsp_valid_o`);
  - `md_valid_o` & `md_stall_i` in the same cycle.
- **busy_o** = FIFO non-empty | `div_inflight`.

## Timing
- **Reset values.** `req_ready_o`=0, `md_valid_o`=0, `md_inst_o`=0, `rsp_valid_o`=0, `busy_o`=0, `err_o`=0. The FIFO is emptied, `div_inflight`=0 and the pointer = 0.
- **Reset mid-operation.** All in-flight ops are discarded and no responses are produced. The unit shares `rst_i`.
- **MUL latency.** Accept at cycle N gives `rsp_valid_o` at N+2. Throughput is 1 MUL/cycle.
- **DIV latency.** Accept at N gives `rsp_valid_o` at N+34. No other request is accepted from N+1 through N+34 inclusive; the next grant can occur at N+35.
- **MUL then DIV.** A MUL at N blocks a DIV until the FIFO drains. The earliest DIV grant is N+3, the cycle after the MUL response at N+2.
- **Request hold.** Requests may be withdrawn or changed while not accepted. There is no ordering guarantee between requesters beyond the grant order.

## Structure
- **Shared package `uriscv_muldiv_pkg`.** Holds the funct3 op constants, the op-to-one-hot decode function, and the latency constants MUL_LAT=2 and DIV_LAT=34 (used by the bench).
- **Sub-module `uriscv_muldiv_arb_fifo`.** A parameterised-width, depth-2 in-order FIFO with push, pop, full, empty and head outputs.
- The arbiter holds the eligibility logic, the round-robin pointer, the issue mux, response steering and the error logic.
- **Bench.** Instantiates the arbiter with the real `uriscv_muldiv`.

## Test plan
- **Single MUL.** Requester 0 MUL a=7, b=6, tag=3 at cycle N → `rsp_valid_o`=01 at N+2, data=42, tag=3. `err_o`=0.
- **Round-robin MULs.** Both requesters request MUL every cycle for 6 cycles → grants alternate 0,1,0,1,…; one response per cycle from N+2 with matching ids and tags; the FIFO never overflows.
- **DIV blocking.** Requester 1 DIV a=-20, b=3 at N; requester 0 holds MULH 0x80000000×2 → requester 0 is not accepted until N+35. Requester 1 gets -6 at N+34; requester 0 then gets 0xFFFFFFFF at N+37.
- **DIV behind MUL.** Requester 0 MUL at N, requester 1 REMU 10,0 presented at N+1 → REMU granted at N+3, result 10 at N+37. `md_valid_o`&`md_stall_i` is never seen.
- **Reset mid-DIV.** Assert `rst_i` at N+10 of a DIVU, release at N+12, then issue a MULHU 0xFFFFFFFF×0xFFFFFFFF → no stale response; 0xFFFFFFFE is returned 2 cycles after the new accept.
- **Error injection.** Force `md_ready_i`=1 for one cycle with the FIFO empty → `err_o`=1 and stays 1 until reset; no `rsp_valid_o`.

Source files
------------

// File: rtl/uriscv_muldiv_pkg.sv
// Shared definitions for the uriscv_muldiv arbiter and its bench.
//   - funct3 op encoding of the M extension (MUL..REMU)
//   - op_onehot(): funct3 -> one-hot inst_* vector (bit k = funct3 k)
//   - op_is_div(): funct3[2] selects the DIV class
//   - MUL_LAT / DIV_LAT: accept-to-response latency of the unit in cycles
//   - ORD_DEPTH: depth of the in-order response FIFO
package uriscv_muldiv_pkg;

  localparam int MUL_LAT   = 2;
  localparam int DIV_LAT   = 34;
  localparam int ORD_DEPTH = 2;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  function automatic logic [7:0] op_onehot(input logic [2:0] op);
    logic [7:0] oh;
    oh     = '0;
    oh[op] = 1'b1;
    return oh;
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/uriscv_muldiv_arb_fifo.sv
// In-order FIFO of ORD_DEPTH (2) entries used to remember which requester
// (and tag) owns each op currently inside the muldiv unit.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset (empties the FIFO)
//   push_i, data_i write an entry (ignored when full unless popping too)
//   pop_i          drop the head entry (ignored when empty)
//   full_o         ORD_DEPTH entries held
//   empty_o        no entries held
//   head_o         oldest entry, valid when !empty_o
module uriscv_muldiv_arb_fifo
  import uriscv_muldiv_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic         do_pop, do_push;

  assign full_o  = (count_q == 2'(ORD_DEPTH));
  assign empty_o = (count_q == 2'd0);
  assign head_o  = e0_q;

  always_comb begin
    count_d = count_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO is only taken when the head leaves this cycle.
    do_push = push_i & (~full_o | do_pop);
    case ({do_push, do_pop})
      2'b10: begin
        if (empty_o) e0_d = data_i;
        else         e1_d = data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        e0_d    = e1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          e0_d = data_i;
        end else begin
          e0_d = e1_q;
          e1_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= 2'd0;
    else       count_q <= count_d;
  end

  // Entry storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk_i) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

endmodule

// File: rtl/uriscv_muldiv_arb.sv
// Two-port round-robin arbiter/sequencer in front of one uriscv_muldiv unit.
// Grants at most one eligible request per cycle, encodes it onto the unit's
// one-hot inst_* inputs, tracks unit occupancy so it never issues into a
// stall, and steers each in-order result back to its requester with its tag.
// Ports:
//   clk_i, rst_i                     clock, async active-high reset
//   req_valid_i/req_ready_o [1:0]    per-requester handshake
//   req_op_i, req_a_i, req_b_i       per-requester funct3 op and operands
//   req_tag_i                        per-requester tag, echoed on response
//   rsp_valid_o [1:0]                one-cycle response pulse per requester
//   rsp_data_o, rsp_tag_o            shared response payload
//   md_valid_o, md_inst_o            unit valid_i and one-hot inst_*_i
//   md_ra_o, md_rb_o                 unit operands
//   md_stall_i, md_ready_i           unit stall_o, ready_o
//   md_result_i                      unit result_o
//   busy_o                           any op in flight
//   err_o                            sticky protocol error
module uriscv_muldiv_arb
  import uriscv_muldiv_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0][2:0]       req_op_i,
  input  logic [1:0][31:0]      req_a_i,
  input  logic [1:0][31:0]      req_b_i,
  input  logic [1:0][TAG_W-1:0] req_tag_i,
  output logic [1:0]            rsp_valid_o,
  output logic [31:0]           rsp_data_o,
  output logic [TAG_W-1:0]      rsp_tag_o,
  output logic                  md_valid_o,
  output logic [7:0]            md_inst_o,
  output logic [31:0]           md_ra_o,
  output logic [31:0]           md_rb_o,
  input  logic                  md_stall_i,
  input  logic                  md_ready_i,
  input  logic [31:0]           md_result_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int ENT_W = TAG_W + 1;

  logic             fifo_full, fifo_empty;
  logic [ENT_W-1:0] fifo_head, fifo_wdata;
  logic             ptr_q, ptr_d;
  logic             div_inflight_q, div_inflight_d;
  logic             err_q, err_d;
  logic [1:0]       elig, grant;
  logic             win, room;

  uriscv_muldiv_arb_fifo #(.W(ENT_W)) u_order_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (md_valid_o),
    .data_i  (fifo_wdata),
    .pop_i   (md_ready_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_comb begin
    // With a full FIFO a new op only fits if the head returns this cycle;
    // the unit's fixed MUL latency makes that the normal case.
    room = ~fifo_full | md_ready_i;

    // Any op waits behind a DIV; a DIV additionally waits for the unit to
    // drain so it never lands behind a MUL still in the pipe.
    elig[0] = req_valid_i[0] & ~rst_i & ~div_inflight_q & room &
              (~op_is_div(req_op_i[0]) | fifo_empty);
    elig[1] = req_valid_i[1] & ~rst_i & ~div_inflight_q & room &
              (~op_is_div(req_op_i[1]) | fifo_empty);

    if (elig == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
    else               grant = elig;
    win = grant[1];

    req_ready_o = grant;
    md_valid_o  = |grant;
    md_inst_o   = md_valid_o ? op_onehot(req_op_i[win]) : 8'h00;
    md_ra_o     = req_a_i[win];
    md_rb_o     = req_b_i[win];
    fifo_wdata  = {win, req_tag_i[win]};

    ptr_d = ptr_q;
    if (grant[0])      ptr_d = 1'b1;
    else if (grant[1]) ptr_d = 1'b0;

    // While a DIV is in flight it is the only FIFO entry, so the next
    // md_ready_i is necessarily its result.
    div_inflight_d = div_inflight_q;
    if (md_valid_o & op_is_div(req_op_i[win])) div_inflight_d = 1'b1;
    else if (md_ready_i & div_inflight_q)      div_inflight_d = 1'b0;

    err_d = err_q | (md_ready_i & fifo_empty) | (md_valid_o & md_stall_i);

    rsp_valid_o = 2'b00;
    if (md_ready_i & ~fifo_empty) rsp_valid_o[fifo_head[TAG_W]] = 1'b1;
    rsp_data_o = md_result_i;
    rsp_tag_o  = fifo_head[TAG_W-1:0];

    busy_o = ~fifo_empty | div_inflight_q;
    err_o  = err_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q          <= 1'b0;
      div_inflight_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      ptr_q          <= ptr_d;
      div_inflight_q <= div_inflight_d;
      err_q          <= err_d;
    end
  end

endmodule
